fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Issue/writeback sequencer sitting directly upstream of the floating-point ALU in the pipelined CPU. It accepts one FP operation from the execute stage and holds operands and opcode stable toward the ALU. It pulses the ALU start, waits for the ALU ready handshake under a watchdog, and registers the result and flags for writeback. While the operation is in flight it stalls the pipeline and accumulates sticky exception flags (fflags).

## Interface
Parameters:
- MAX_WAIT, 31: WAIT-state cycles without ready before a timeout; legal range 1–31.

Ports:
- iclock  in  1  single clock; all state updates on its rising edge
- ireset  in  1  synchronous, active-high reset
- ivalid  in  1  execute stage presents an FP operation; held high while stalled
- icontrol  in  5  FP opcode (FOPADD…FOPMOV encoding)
- idataa, idatab  in  32  operands
- ird  in  5  destination register index
- iflush  in  1  kill the in-flight operation (branch/trap)
- iflags_clear  in  1  clear sticky flags (fcsr write)
- oalu_dataa, oalu_datab  out  32  registered operands to ALU
- oalu_control  out  5  registered opcode to ALU
- oalu_start  out  1  one-cycle start pulse to ALU istart
- ialu_ready  in  1  ALU oready
- ialu_result  in  32  ALU oresult
- ialu_nan, ialu_overflow, ialu_underflow  in  1  ALU exception flags
- ostall  out  1  hold upstream pipeline
- owb_en  out  1  one-cycle writeback strobe
- owb_rd  out  5  writeback register index
- owb_data  out  32  writeback value
- oflags  out  5  sticky {NV,DZ,OF,UF,NX}
- otimeout  out  1  sticky watchdog error

## Operation
- States: IDLE, START, WAIT, WB.
- IDLE:
  - If ivalid and not iflush: capture icontrol, idataa, idatab and ird into the oalu_* registers and the rd register, then go to START.
  - Otherwise stay in IDLE.
- START:
  - oalu_start=1 for exactly this cycle; watchdog count cleared to 0.
  - Next state WAIT, or IDLE if iflush.
- WAIT:
  - If iflush: go to IDLE; no writeback, no flag update.
  - Else if ialu_ready: capture ialu_result and flags, go to WB with writeback enabled.
  - Else if count == MAX_WAIT-1: set otimeout, go to WB with writeback suppressed.
  - Else: count += 1 (5-bit, never wraps because MAX_WAIT ≤ 31).
- WB:
  - owb_en=1 only if the result was captured; owb_rd and owb_data are valid.
  - Always returns to IDLE. ivalid is ignored in WB because it is the same instruction being released.
- ostall = (IDLE & ivalid & ~iflush) | START | WAIT. It is 0 in WB.
- oalu_dataa, oalu_datab and oalu_control hold their values from capture until the next capture; they do not change in START, WAIT or WB.
- Flags on a captured writeback:
  - NV |= ialu_nan, OF |= ialu_overflow, UF |= ialu_underflow.
  - DZ and NX are always 0.
  - Update rule: oflags <= (iflags_clear ? 0 : oflags) | new_bits. A same-cycle set wins over clear for those bits.
- iflags_clear in any other cycle: oflags <= 0.
- otimeout is cleared only by ireset.
- iflush in IDLE blocks acceptance; iflush in WB has no effect because the writeback is already committed.

## Timing
- Reset (ireset=1 at an edge):
  - State returns to IDLE, including mid-operation.
  - All outputs become 0: oalu_*, oalu_start, ostall (registered part), owb_*, oflags, otimeout.
  - The watchdog count becomes 0.
- Accept at cycle T (IDLE & ivalid):
  - T+1: START, oalu_start=1.
  - T+2 onward: WAIT.
- ialu_ready sampled high at cycle W (in WAIT):
  - WB at W+1 with owb_en=1.
  - Pipeline advances at the end of W+1.
  - A new op can be accepted at W+2.
- Minimum total occupancy is 4 cycles (ready at T+2 → WB at T+3).
- ialu_ready sampled in START is ignored, because it is the stale ready from the previous op.
- Timeout: with no ready, WB occurs MAX_WAIT WAIT-cycles after START, with otimeout=1 from the WB cycle on.
- Back-to-back ops: no bubble inside the block beyond the IDLE cycle after WB.

## Test plan
- Reset mid-WAIT: accept FOPADD, assert ireset 3 cycles later → next cycle state is IDLE; ostall, oalu_start, owb_en and oflags are all 0.
- Nominal: accept FOPADD with a=0x3F800000, b=0x40000000, ird=5 at T; ALU ready with result 0x40400000 at T+10 → oalu_start=1 only at T+1, ostall=1 T..T+10, owb_en=1 at T+11 with owb_rd=5 and owb_data=0x40400000.
- Flags: two ops, the first returning nan=1 and the second overflow=1 → oflags=5'b10100. iflags_clear asserted in the same cycle as a writeback carrying underflow=1 → oflags=5'b00010.
- Flush: iflush asserted in the 3rd WAIT cycle → IDLE next cycle; owb_en never asserted; oflags unchanged; a late ialu_ready is ignored.
- Timeout: MAX_WAIT=4, ready held 0 → WB reached 4 WAIT cycles after START, owb_en=0, otimeout=1 and it stays 1 after the next op completes normally.
- Back-to-back: ivalid held high with a second op presented right after WB → second accept in the cycle after WB; oalu_dataa updates only then; a stale ready in START does not cause an early WB.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback sequencer in front of the FP ALU: holds one operation, pulses start,
// waits for ready under a watchdog, then presents a single-cycle writeback.
module fpu_issue_ctrl #(
  parameter int MAX_WAIT = 31
) (
  input  logic        iclock,
  input  logic        ireset,
  input  logic        ivalid,
  input  logic [4:0]  icontrol,
  input  logic [31:0] idataa,
  input  logic [31:0] idatab,
  input  logic [4:0]  ird,
  input  logic        iflush,
  input  logic        iflags_clear,
  output logic [31:0] oalu_dataa,
  output logic [31:0] oalu_datab,
  output logic [4:0]  oalu_control,
  output logic        oalu_start,
  input  logic        ialu_ready,
  input  logic [31:0] ialu_result,
  input  logic        ialu_nan,
  input  logic        ialu_overflow,
  input  logic        ialu_underflow,
  output logic        ostall,
  output logic        owb_en,
  output logic [4:0]  owb_rd,
  output logic [31:0] owb_data,
  output logic [4:0]  oflags,
  output logic        otimeout
);

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic        wb_hit;
  logic [2:0]  exc_p1;
  logic        accept, ready_hit, wd_expired;
  logic [4:0]  set_bits;

  assign accept     = (state == IDLE) && ivalid && !iflush;
  assign ready_hit  = (state == WAIT) && !iflush && ialu_ready;
  assign wd_expired = (state == WAIT) && !iflush && !ialu_ready && (count == 5'(MAX_WAIT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = iflush ? IDLE : WAIT;
      WAIT: begin
        if (iflush)                        state_nxt = IDLE;
        else if (ready_hit || wd_expired)  state_nxt = WB;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky exception bits are folded in during the WB cycle; a same-cycle set beats a clear.
  assign set_bits = (state == WB && wb_hit) ? {exc_p1[2], 1'b0, exc_p1[1], exc_p1[0], 1'b0} : 5'b0;

  always_ff @(posedge iclock) begin
    if (ireset) begin
      state        <= IDLE;
      count        <= 5'd0;
      wb_hit       <= 1'b0;
      exc_p1       <= 3'b0;
      oalu_dataa   <= 32'd0;
      oalu_datab   <= 32'd0;
      oalu_control <= 5'd0;
      owb_rd       <= 5'd0;
      owb_data     <= 32'd0;
      oflags       <= 5'd0;
      otimeout     <= 1'b0;
    end else begin
      state  <= state_nxt;
      oflags <= (iflags_clear ? 5'b0 : oflags) | set_bits;
      if (accept) begin
        oalu_dataa   <= idataa;
        oalu_datab   <= idatab;
        oalu_control <= icontrol;
        owb_rd       <= ird;
      end
      if (state == START) begin
        count  <= 5'd0;
        wb_hit <= 1'b0;
      end else if (state == WAIT && !iflush && !ialu_ready && !wd_expired) begin
        count <= count + 5'd1;
      end
      if (ready_hit) begin
        wb_hit   <= 1'b1;
        owb_data <= ialu_result;
        exc_p1   <= {ialu_nan, ialu_overflow, ialu_underflow};
      end
      if (wd_expired) begin
        wb_hit   <= 1'b0;
        otimeout <= 1'b1;
      end
    end
  end

  assign oalu_start = (state == START);
  assign owb_en     = (state == WB) && wb_hit;
  assign ostall     = accept || (state == START) || (state == WAIT);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: writebacks go through a scoreboard queue,
// a second instance with a short watchdog covers the timeout path.
module tb_fpu_issue_ctrl;

  logic        iclock = 1'b0;
  logic        ireset, ivalid, iflush, iflags_clear, ialu_ready;
  logic [4:0]  icontrol, ird;
  logic [31:0] idataa, idatab, ialu_result;
  logic        ialu_nan, ialu_overflow, ialu_underflow;
  logic [31:0] alu_a, alu_b, wb_data;
  logic [4:0]  alu_ctl, wb_rd, flags;
  logic        alu_start, stall, wb_en, tmo;

  logic        t_ivalid, t_ready;
  logic [31:0] t_alu_a, t_alu_b, t_wb_data;
  logic [4:0]  t_alu_ctl, t_wb_rd, t_flags;
  logic        t_start, t_stall, t_wb_en, t_tmo;

  int total = 0;
  int bad   = 0;
  logic [36:0] sb[$];

  always #5 iclock = ~iclock;

  fpu_issue_ctrl #(.MAX_WAIT(31)) dut (
    .iclock(iclock), .ireset(ireset), .ivalid(ivalid), .icontrol(icontrol),
    .idataa(idataa), .idatab(idatab), .ird(ird), .iflush(iflush),
    .iflags_clear(iflags_clear), .oalu_dataa(alu_a), .oalu_datab(alu_b),
    .oalu_control(alu_ctl), .oalu_start(alu_start), .ialu_ready(ialu_ready),
    .ialu_result(ialu_result), .ialu_nan(ialu_nan), .ialu_overflow(ialu_overflow),
    .ialu_underflow(ialu_underflow), .ostall(stall), .owb_en(wb_en), .owb_rd(wb_rd),
    .owb_data(wb_data), .oflags(flags), .otimeout(tmo)
  );

  fpu_issue_ctrl #(.MAX_WAIT(4)) dut4 (
    .iclock(iclock), .ireset(ireset), .ivalid(t_ivalid), .icontrol(icontrol),
    .idataa(idataa), .idatab(idatab), .ird(ird), .iflush(iflush),
    .iflags_clear(iflags_clear), .oalu_dataa(t_alu_a), .oalu_datab(t_alu_b),
    .oalu_control(t_alu_ctl), .oalu_start(t_start), .ialu_ready(t_ready),
    .ialu_result(ialu_result), .ialu_nan(ialu_nan), .ialu_overflow(ialu_overflow),
    .ialu_underflow(ialu_underflow), .ostall(t_stall), .owb_en(t_wb_en), .owb_rd(t_wb_rd),
    .owb_data(t_wb_data), .oflags(t_flags), .otimeout(t_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclock);
    #1;
  endtask

  // Scoreboard: every writeback strobe of the main instance must match the oldest pushed entry.
  always @(negedge iclock) begin
    if (wb_en === 1'b1) begin
      if (sb.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  // Accept at T, START at T+1, `waits` WAIT cycles without ready, then ready, then WB.
  task automatic run_op(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int waits, input logic [31:0] res,
                        input logic n, input logic o, input logic u, input logic clr);
    ivalid = 1'b1; icontrol = ctl; idataa = a; idatab = b; ird = rd;
    #1 chk("acc_stall", {31'd0, stall}, 32'd1);
    chk("acc_nostart", {31'd0, alu_start}, 32'd0);
    tick();
    chk("start_pulse", {31'd0, alu_start}, 32'd1);
    chk("start_alu_a", alu_a, a);
    chk("start_alu_b", alu_b, b);
    chk("start_alu_ctl", {27'd0, alu_ctl}, {27'd0, ctl});
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait_nostart", {31'd0, alu_start}, 32'd0);
      chk("wait_stall", {31'd0, stall}, 32'd1);
    end
    tick();
    ialu_ready = 1'b1; ialu_result = res; ialu_nan = n; ialu_overflow = o; ialu_underflow = u;
    sb.push_back({rd, res});
    #1 chk("ready_stall", {31'd0, stall}, 32'd1);
    tick();
    ialu_ready = 1'b0; ialu_nan = 1'b0; ialu_overflow = 1'b0; ialu_underflow = 1'b0;
    ivalid = 1'b0; iflags_clear = clr;
    #1 chk("wb_strobe", {31'd0, wb_en}, 32'd1);
    chk("wb_nostall", {31'd0, stall}, 32'd0);
    tick();
    iflags_clear = 1'b0;
    #1 chk("post_wb_en", {31'd0, wb_en}, 32'd0);
  endtask

  initial begin
    ireset = 1'b1; ivalid = 1'b0; iflush = 1'b0; iflags_clear = 1'b0; ialu_ready = 1'b0;
    icontrol = 5'd0; ird = 5'd0; idataa = 32'd0; idatab = 32'd0; ialu_result = 32'd0;
    ialu_nan = 1'b0; ialu_overflow = 1'b0; ialu_underflow = 1'b0;
    t_ivalid = 1'b0; t_ready = 1'b0;
    tick(); tick();
    ireset = 1'b0;
    #1 chk("rst_start", {31'd0, alu_start}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_flags", {27'd0, flags}, 32'd0);
    chk("rst_tmo", {31'd0, tmo}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);

    // Reset mid-WAIT
    ivalid = 1'b1; icontrol = 5'd0; idataa = 32'h3F800000; idatab = 32'h40000000; ird = 5'd7;
    tick(); tick(); tick();
    ireset = 1'b1;
    tick();
    ireset = 1'b0; ivalid = 1'b0;
    #1 chk("rstw_stall", {31'd0, stall}, 32'd0);
    chk("rstw_start", {31'd0, alu_start}, 32'd0);
    chk("rstw_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rstw_flags", {27'd0, flags}, 32'd0);
    chk("rstw_alu_a", alu_a, 32'd0);
    tick();
    chk("rstw_idle", {31'd0, stall}, 32'd0);

    // Nominal: ready at T+10, WB at T+11
    run_op(5'd0, 32'h3F800000, 32'h40000000, 5'd5, 8, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nom_flags", {27'd0, flags}, 32'd0);

    // Sticky flags, then clear colliding with an underflow writeback
    run_op(5'd1, 32'h1, 32'h2, 5'd1, 2, 32'h7FC00000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flag_nv", {27'd0, flags}, 32'b10000);
    run_op(5'd2, 32'h3, 32'h4, 5'd2, 0, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flag_nv_of", {27'd0, flags}, 32'b10100);
    run_op(5'd3, 32'h5, 32'h6, 5'd3, 1, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flag_clr_uf", {27'd0, flags}, 32'b00010);
    iflags_clear = 1'b1;
    tick();
    iflags_clear = 1'b0;
    #1 chk("flag_clear", {27'd0, flags}, 32'd0);
    run_op(5'd1, 32'h7, 32'h8, 5'd4, 0, 32'h7FC00001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flag_nv2", {27'd0, flags}, 32'b10000);

    // Flush in the 3rd WAIT cycle; a ready in that cycle and later must be ignored
    ivalid = 1'b1; icontrol = 5'd0; idataa = 32'hAAAA0000; idatab = 32'h1; ird = 5'd9;
    tick(); tick(); tick(); tick();
    iflush = 1'b1; ialu_ready = 1'b1; ialu_overflow = 1'b1; ialu_result = 32'hDEAD0000;
    tick();
    iflush = 1'b0; ivalid = 1'b0;
    #1 chk("flush_idle", {31'd0, stall}, 32'd0);
    chk("flush_wb_en", {31'd0, wb_en}, 32'd0);
    tick(); tick();
    chk("flush_late_wb", {31'd0, wb_en}, 32'd0);
    ialu_ready = 1'b0; ialu_overflow = 1'b0;
    tick();
    chk("flush_flags", {27'd0, flags}, 32'b10000);

    // Back-to-back with ivalid held; stale ready in START
    ivalid = 1'b1; icontrol = 5'd4; idataa = 32'h11111111; idatab = 32'h0; ird = 5'd10;
    tick();
    tick();
    ialu_ready = 1'b1; ialu_result = 32'hAAAA1111; sb.push_back({5'd10, 32'hAAAA1111});
    tick();
    ialu_ready = 1'b0; icontrol = 5'd2; idataa = 32'h22222222; ird = 5'd11;
    #1 chk("b2b_wb", {31'd0, wb_en}, 32'd1);
    chk("b2b_hold_a", alu_a, 32'h11111111);
    tick();
    chk("b2b_accept", {31'd0, stall}, 32'd1);
    chk("b2b_hold_a2", alu_a, 32'h11111111);
    tick();
    ialu_ready = 1'b1;
    #1 chk("b2b_start", {31'd0, alu_start}, 32'd1);
    chk("b2b_new_a", alu_a, 32'h22222222);
    tick();
    ialu_ready = 1'b0;
    #1 chk("b2b_no_early_wb", {31'd0, wb_en}, 32'd0);
    chk("b2b_wait_stall", {31'd0, stall}, 32'd1);
    ialu_ready = 1'b1; ialu_result = 32'hBBBB2222; sb.push_back({5'd11, 32'hBBBB2222});
    tick();
    ialu_ready = 1'b0; ivalid = 1'b0;
    #1 chk("b2b_wb2", {31'd0, wb_en}, 32'd1);
    tick();

    // Watchdog on the MAX_WAIT=4 instance
    t_ivalid = 1'b1; idataa = 32'h33333333;
    tick();
    chk("to_start", {31'd0, t_start}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait_stall", {31'd0, t_stall}, 32'd1);
      chk("to_wait_tmo", {31'd0, t_tmo}, 32'd0);
    end
    tick();
    t_ivalid = 1'b0;
    #1 chk("to_wb_stall", {31'd0, t_stall}, 32'd0);
    chk("to_wb_en", {31'd0, t_wb_en}, 32'd0);
    chk("to_tmo", {31'd0, t_tmo}, 32'd1);
    tick();
    t_ivalid = 1'b1; idataa = 32'h44444444;
    tick();
    tick();
    t_ready = 1'b1; ialu_result = 32'hCCCC3333;
    tick();
    t_ready = 1'b0; t_ivalid = 1'b0;
    #1 chk("to_norm_wb", {31'd0, t_wb_en}, 32'd1);
    chk("to_norm_data", t_wb_data, 32'hCCCC3333);
    tick();
    chk("to_sticky", {31'd0, t_tmo}, 32'd1);
    chk("main_tmo_clear", {31'd0, tmo}, 32'd0);

    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
